// File: rtl/servo_pwm_generator.sv
// Two-channel servo PWM stage: maps 8-bit X/Y duty words onto fixed-period
// pulse trains, with duty updates double-buffered to frame boundaries.
module servo_pwm_generator #(
    parameter int unsigned CLK_DIV      = 50,
    parameter int unsigned PERIOD_TICKS = 20000,
    parameter int unsigned MIN_PULSE    = 1000,
    parameter int unsigned STEP         = 4
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iEnable,
    input  logic       iDutyValid,
    input  logic [7:0] iXduty,
    input  logic [7:0] iYduty,
    output logic       oXpwm,
    output logic       oYpwm,
    output logic       oFrameStart,
    output logic       oPending
);

    localparam int unsigned DUTY_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_WIDTH = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] STEP_W    = CNT_W'(STEP);

    logic [PRE_W-1:0]  r_prescale;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [DUTY_W-1:0] r_shadow_x;
    logic [DUTY_W-1:0] r_shadow_y;
    logic [DUTY_W-1:0] r_active_x;
    logic [DUTY_W-1:0] r_active_y;
    logic              r_run;

    logic              w_run;
    logic              w_tick;
    logic              w_boundary;
    logic              w_frame_start;
    logic              w_load;
    logic [CNT_W-1:0]  w_width_x;
    logic [CNT_W-1:0]  w_width_y;

    // The first enabled edge acts as a synthetic boundary so every frame,
    // including the first after enable or reset, has the same shape.
    assign w_run         = iEnable & r_run;
    assign w_tick        = w_run & (r_prescale == PRE_LAST);
    assign w_boundary    = w_tick & (r_frame_cnt == CNT_LAST);
    assign w_frame_start = w_boundary | (iEnable & ~r_run);
    assign w_load        = ~w_run | w_boundary;

    // Pulse width in ticks from the active duty words
    assign w_width_x = MIN_WIDTH + CNT_W'(r_active_x) * STEP_W;
    assign w_width_y = MIN_WIDTH + CNT_W'(r_active_y) * STEP_W;

    // Remember whether the previous cycle was enabled
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= iEnable;
        end
    end

    // Prescaler producing one tick every CLK_DIV clocks while running
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_prescale <= '0;
        end else if (!w_run || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRE_W'(1);
        end
    end

    // Frame counter in ticks, wrapping at the frame boundary
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_frame_cnt <= '0;
        end else if (!w_run || w_boundary) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    // Shadow duty capture on strobe; last strobe in a frame wins
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_shadow_x <= '0;
            r_shadow_y <= '0;
        end else if (iDutyValid) begin
            r_shadow_x <= iXduty;
            r_shadow_y <= iYduty;
        end
    end

    // Active duty takes the pre-strobe shadow at boundaries or while idle
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_active_x <= '0;
            r_active_y <= '0;
        end else if (w_load) begin
            r_active_x <= r_shadow_x;
            r_active_y <= r_shadow_y;
        end
    end

    // Pending flag: a strobe always wins over the clear at a load point
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oPending <= 1'b0;
        end else if (iDutyValid) begin
            oPending <= 1'b1;
        end else if (w_load) begin
            oPending <= 1'b0;
        end
    end

    // Registered pulse and frame-start outputs, one clock behind the counter
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oXpwm       <= 1'b0;
            oYpwm       <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oXpwm       <= w_run & (r_frame_cnt < w_width_x);
            oYpwm       <= w_run & (r_frame_cnt < w_width_y);
            oFrameStart <= w_frame_start;
        end
    end

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Bench for servo_pwm_generator: two instances (CLK_DIV 1 and 3) share the
// stimulus; a frame-position model is checked every cycle and directed
// frame measurements are checked against hand-computed widths.
module tb_servo_pwm_generator;

    localparam int unsigned PERIOD = 1200;
    localparam int unsigned MINP   = 100;
    localparam int unsigned STEPV  = 4;
    localparam int          LIMIT  = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dv;
    logic [7:0] xd;
    logic [7:0] yd;

    logic x_a, y_a, fs_a, pd_a;
    logic x_b, y_b, fs_b, pd_b;

    logic sx  [2];
    logic sy  [2];
    logic sfs [2];
    logic spd [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_generator #(
        .CLK_DIV(1), .PERIOD_TICKS(PERIOD), .MIN_PULSE(MINP), .STEP(STEPV)
    ) u_a (
        .iClock(clk), .iReset(rst), .iEnable(en), .iDutyValid(dv),
        .iXduty(xd), .iYduty(yd),
        .oXpwm(x_a), .oYpwm(y_a), .oFrameStart(fs_a), .oPending(pd_a)
    );

    servo_pwm_generator #(
        .CLK_DIV(3), .PERIOD_TICKS(PERIOD), .MIN_PULSE(MINP), .STEP(STEPV)
    ) u_b (
        .iClock(clk), .iReset(rst), .iEnable(en), .iDutyValid(dv),
        .iXduty(xd), .iYduty(yd),
        .oXpwm(x_b), .oYpwm(y_b), .oFrameStart(fs_b), .oPending(pd_b)
    );

    assign sx[0]  = x_a;  assign sx[1]  = x_b;
    assign sy[0]  = y_a;  assign sy[1]  = y_b;
    assign sfs[0] = fs_a; assign sfs[1] = fs_b;
    assign spd[0] = pd_a; assign spd[1] = pd_b;

    initial begin
        assert (MINP + 255 * STEPV < PERIOD)
        else $fatal(1, "FAIL param_range: MIN_PULSE+255*STEP=%0d not below PERIOD=%0d",
                    MINP + 255 * STEPV, PERIOD);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int frame_len(input int k);
        return int'(PERIOD) * div_of(k);
    endfunction

    function automatic int pulse_len(input int duty, input int k);
        return (int'(MINP) + duty * int'(STEPV)) * div_of(k);
    endfunction

    // Model state: position in clocks since the frame-start edge
    bit m_run  [2];
    int m_pos  [2];
    int m_shx  [2];
    int m_shy  [2];
    int m_acx  [2];
    int m_acy  [2];
    bit m_pend [2];
    bit e_x    [2];
    bit e_y    [2];
    bit e_fs   [2];

    // Model: a frame starts on the first enabled edge and every frame_len
    // clocks after; the pulse covers the pulse_len clocks after that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] = 0; m_pos[k] = 0;
                m_shx[k] = 0; m_shy[k] = 0; m_acx[k] = 0; m_acy[k] = 0;
                m_pend[k] = 0; e_x[k] = 0; e_y[k] = 0; e_fs[k] = 0;
            end else begin
                if (!en) begin
                    m_run[k]  = 0;
                    m_acx[k]  = m_shx[k];
                    m_acy[k]  = m_shy[k];
                    m_pend[k] = dv;
                    e_x[k] = 0; e_y[k] = 0; e_fs[k] = 0;
                end else begin
                    if (!m_run[k]) begin
                        m_run[k] = 1;
                        m_pos[k] = 0;
                    end else begin
                        m_pos[k] = (m_pos[k] + 1) % frame_len(k);
                    end
                    if (m_pos[k] == 0) begin
                        m_acx[k]  = m_shx[k];
                        m_acy[k]  = m_shy[k];
                        m_pend[k] = dv;
                        e_fs[k] = 1; e_x[k] = 0; e_y[k] = 0;
                    end else begin
                        m_pend[k] = m_pend[k] | dv;
                        e_fs[k] = 0;
                        e_x[k]  = (m_pos[k] - 1) < pulse_len(m_acx[k], k);
                        e_y[k]  = (m_pos[k] - 1) < pulse_len(m_acy[k], k);
                    end
                end
                if (dv) begin
                    m_shx[k] = int'(xd);
                    m_shy[k] = int'(yd);
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc_x%0d", k),  32'(sx[k]),  32'(e_x[k]));
                check($sformatf("cyc_y%0d", k),  32'(sy[k]),  32'(e_y[k]));
                check($sformatf("cyc_fs%0d", k), 32'(sfs[k]), 32'(e_fs[k]));
                check($sformatf("cyc_pd%0d", k), 32'(spd[k]), 32'(m_pend[k]));
            end
        end
    end

    // Measure one frame of instance k from its frame-start sample to the
    // next, optionally strobing duty words at given offsets into the frame.
    task automatic run_frame(input int k,
                             input int s1, input logic [7:0] x1, input logic [7:0] y1,
                             input int s2, input logic [7:0] x2, input logic [7:0] y2,
                             output int period, output int xh, output int yh,
                             output int last_pend);
        int guard = 0;
        while (!sfs[k] && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= LIMIT) check($sformatf("frame_start_timeout%0d", k), 32'(0), 32'(1));
        period = 0; xh = 0; yh = 0; last_pend = 0;
        do begin
            if (sx[k]) xh++;
            if (sy[k]) yh++;
            last_pend = int'(spd[k]);
            if (period == s1) begin
                dv = 1'b1; xd = x1; yd = y1;
            end else if (period == s2) begin
                dv = 1'b1; xd = x2; yd = y2;
            end else begin
                dv = 1'b0;
            end
            period++;
            @(negedge clk);
        end while (!sfs[k] && period < LIMIT);
        dv = 1'b0;
        if (period >= LIMIT) check($sformatf("frame_end_timeout%0d", k), 32'(0), 32'(1));
    endtask

    task automatic check_frame(input string name, input int p, input int xh, input int yh,
                               input int ep, input int exh, input int eyh);
        check({name, "_period"}, 32'(p),  32'(ep));
        check({name, "_xhigh"},  32'(xh), 32'(exh));
        check({name, "_yhigh"},  32'(yh), 32'(eyh));
    endtask

    initial begin
        int p, xh, yh, lp;
        rst = 1'b1; en = 1'b0; dv = 1'b0; xd = 8'h00; yd = 8'h00;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_x",  32'(x_a),  32'(0));
        check("rst_y",  32'(y_a),  32'(0));
        check("rst_fs", 32'(fs_a), 32'(0));
        check("rst_pd", 32'(pd_a), 32'(0));

        // 1: enable with no duty write
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("en_fs_first", 32'(fs_a), 32'(1));
        run_frame(0, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f1", p, xh, yh, 1200, 100, 100);

        // 2: mid-frame strobe leaves the current frame alone
        run_frame(0, 300, 8'h28, 8'hFF, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f2", p, xh, yh, 1200, 100, 100);
        check("f2_pend_before_bnd", 32'(lp), 32'(1));
        check("f2_pend_after_bnd",  32'(pd_a), 32'(0));

        // 3: two strobes in one frame, last one wins
        run_frame(0, 200, 8'h10, 8'h01, 400, 8'h80, 8'h00, p, xh, yh, lp);
        check_frame("f3", p, xh, yh, 1200, 260, 1120);

        // 4: strobe coincident with the boundary
        run_frame(0, 1199, 8'h40, 8'h40, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f4", p, xh, yh, 1200, 612, 100);
        check("f4_pend_held", 32'(pd_a), 32'(1));
        run_frame(0, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f5", p, xh, yh, 1200, 612, 100);
        run_frame(0, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f6", p, xh, yh, 1200, 356, 356);

        // 5: drop enable mid-pulse, capture while idle, re-enable
        repeat (50) @(negedge clk);
        check("dis_x_before", 32'(x_a), 32'(1));
        en = 1'b0;
        @(negedge clk);
        check("dis_x",  32'(x_a),  32'(0));
        check("dis_y",  32'(y_a),  32'(0));
        check("dis_fs", 32'(fs_a), 32'(0));
        dv = 1'b1; xd = 8'h20; yd = 8'h20;
        @(negedge clk);
        dv = 1'b0;
        check("dis_pend_set", 32'(pd_a), 32'(1));
        @(negedge clk);
        check("dis_pend_clr", 32'(pd_a), 32'(0));
        repeat (10) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("reen_fs", 32'(fs_a), 32'(1));
        run_frame(0, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("reen", p, xh, yh, 1200, 228, 228);

        // 6: reset mid-pulse with full duty active
        run_frame(0, 100, 8'hFF, 8'hFF, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("f_pre_ff", p, xh, yh, 1200, 228, 228);
        repeat (500) @(negedge clk);
        check("ff_x_high", 32'(x_a), 32'(1));
        check("ff_y_high", 32'(y_a), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_x",  32'(x_a),  32'(0));
        check("mrst_y",  32'(y_a),  32'(0));
        check("mrst_pd", 32'(pd_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("post_rst", p, xh, yh, 1200, 100, 100);

        // 6b: CLK_DIV=3 instance after a fresh reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame(1, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("div3_f1", p, xh, yh, 3600, 300, 300);
        run_frame(1, 1000, 8'h28, 8'hFF, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("div3_f2", p, xh, yh, 3600, 300, 300);
        check("div3_pend", 32'(lp), 32'(1));
        run_frame(1, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, p, xh, yh, lp);
        check_frame("div3_f3", p, xh, yh, 3600, 780, 3360);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
